// File: rtl/dice_pkg.sv
// rtl/dice_pkg.sv - shared dice types and constants for the game FSM and display decoder
package dice_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SPIN    = 2'd1,
    PRESENT = 2'd2
  } state_t;

  localparam logic [2:0] DIE_MIN = 3'd1;
  localparam logic [2:0] DIE_MAX = 3'd6;

  function automatic logic [2:0] die_step(input logic [2:0] d);
    return (d == DIE_MAX) ? DIE_MIN : d + 3'd1;
  endfunction

endpackage

// File: rtl/roll_debouncer.sv
// rtl/roll_debouncer.sv - synchroniser and debouncer for an active-low push button
module roll_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_n,
  output logic level,
  output logic press_pulse
);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic             sample;

  // level and sample are active-high "pressed"
  assign sample = ~sync2;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      cnt         <= '0;
      level       <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      sync1       <= raw_n;
      sync2       <= sync1;
      press_pulse <= 1'b0;
      if (sample != level) begin
        if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level       <= sample;
          cnt         <= '0;
          press_pulse <= sample;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/dice_roll_sequencer.sv
// rtl/dice_roll_sequencer.sv - spins two dice while the roll button is held and offers the result
module dice_roll_sequencer
  import dice_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int MIN_SPIN_CYCLES = 16,
  parameter int CNT_W           = 18
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       roll,
  input  logic       roll_ack,
  output logic [2:0] die1,
  output logic [2:0] die2,
  output logic [3:0] sum,
  output logic       roll_valid,
  output logic       spinning
);

  localparam int SPIN_W = $clog2(MIN_SPIN_CYCLES + 1);

  state_t            state;
  state_t            state_next;
  logic              level;
  logic              press_pulse;
  logic [SPIN_W-1:0] spin_cnt;
  logic              release_seen;
  logic              spin_done;
  logic              released;

  roll_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debouncer (
    .clock      (clock),
    .reset      (reset),
    .raw_n      (roll),
    .level      (level),
    .press_pulse(press_pulse)
  );

  assign spin_done  = (spin_cnt == SPIN_W'(MIN_SPIN_CYCLES));
  // an early release is latched so a re-press cannot extend the spin
  assign released   = ~level | release_seen;
  assign roll_valid = (state == PRESENT);
  assign spinning   = (state == SPIN);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (press_pulse) state_next = SPIN;
      SPIN:    if (released && spin_done) state_next = PRESENT;
      PRESENT: if (roll_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      die1         <= DIE_MIN;
      die2         <= DIE_MIN;
      sum          <= 4'd2;
      spin_cnt     <= '0;
      release_seen <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          spin_cnt     <= '0;
          release_seen <= 1'b0;
        end
        SPIN: begin
          if (state_next == PRESENT) begin
            sum <= {1'b0, die1} + {1'b0, die2};
          end else begin
            die1 <= die_step(die1);
            if (die1 == DIE_MAX) die2 <= die_step(die2);
            if (!spin_done) spin_cnt <= spin_cnt + 1'b1;
            if (!level) release_seen <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dice_roll_sequencer.sv
// tb/tb_dice_roll_sequencer.sv - self-checking bench for dice_roll_sequencer
module tb_dice_roll_sequencer;

  localparam int DEB = 4;
  localparam int MIN = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       roll;
  logic       roll_ack;
  logic [2:0] die1;
  logic [2:0] die2;
  logic [3:0] sum;
  logic       roll_valid;
  logic       spinning;

  int checks   = 0;
  int failures = 0;

  dice_roll_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .MIN_SPIN_CYCLES(MIN),
    .CNT_W          (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .roll      (roll),
    .roll_ack  (roll_ack),
    .die1      (die1),
    .die2      (die2),
    .sum       (sum),
    .roll_valid(roll_valid),
    .spinning  (spinning)
  );

  always #5 clock = ~clock;

  // model: dice pair as one index 0..35, button as sample history
  int m_state;
  int m_idx;
  int m_sum;
  int m_spins;
  bit m_rel;
  bit m_level;
  bit m_pulse;
  bit m_ready = 1'b0;
  bit raw_q[$];
  bit syn_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    bit old_level;
    bit old_pulse;
    bit s;
    bit all_diff;
    if (reset) begin
      m_state = 0; m_idx = 0; m_sum = 2; m_spins = 0;
      m_rel = 0; m_level = 0; m_pulse = 0;
      raw_q = '{1'b1, 1'b1};
      syn_q.delete();
      m_ready = 1'b1;
    end else begin
      old_level = m_level;
      old_pulse = m_pulse;
      raw_q.push_back(roll);
      s = !raw_q[raw_q.size() - 3];
      if (raw_q.size() > 4) void'(raw_q.pop_front());
      syn_q.push_back(s);
      m_pulse = 0;
      if (syn_q.size() >= DEB) begin
        all_diff = 1;
        for (int i = 0; i < DEB; i++)
          if (syn_q[syn_q.size() - 1 - i] == m_level) all_diff = 0;
        if (all_diff) begin
          m_level = s;
          m_pulse = s;
          syn_q.delete();
        end else if (syn_q.size() > DEB) begin
          void'(syn_q.pop_front());
        end
      end
      case (m_state)
        0: if (old_pulse) begin m_state = 1; m_spins = 0; m_rel = 0; end
        1: begin
          if ((m_rel || !old_level) && m_spins >= MIN) begin
            m_state = 2;
            m_sum = (m_idx % 6 + 1) + (m_idx / 6 + 1);
          end else begin
            m_idx = (m_idx + 1) % 36;
            m_spins++;
            if (!old_level) m_rel = 1;
          end
        end
        default: if (roll_ack) m_state = 0;
      endcase
    end
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  initial forever begin
    @(negedge clock);
    if (m_ready) begin
      chk("cyc_die1", die1, m_idx % 6 + 1);
      chk("cyc_die2", die2, m_idx / 6 + 1);
      chk("cyc_sum", sum, m_sum);
      chk("cyc_roll_valid", roll_valid, int'(m_state == 2));
      chk("cyc_spinning", spinning, int'(m_state == 1));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_spinning(output int k);
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (spinning !== 1'b1 && k < 60);
    chk("spin_start", spinning, 1);
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (roll_valid !== 1'b1 && k < 60);
    chk("valid_rise", roll_valid, 1);
  endtask

  task automatic chk_dice(input string name, input int d1, input int d2, input int s);
    chk({name, "_die1"}, die1, d1);
    chk({name, "_die2"}, die2, d2);
    chk({name, "_sum"}, sum, s);
  endtask

  initial begin
    int k;
    reset = 1'b1; roll = 1'b1; roll_ack = 1'b0;
    cyc(2);
    chk_dice("reset", 1, 1, 2);
    chk("reset_valid", roll_valid, 0);
    chk("reset_spinning", spinning, 0);
    reset = 1'b0;

    // short glitch: three low samples never reach the debounce threshold
    roll = 1'b0; cyc(3); roll = 1'b1; cyc(10);
    chk("glitch_spinning", spinning, 0);

    // press, spin 7 steps, release
    roll = 1'b0;
    wait_spinning(k);
    chk("press_latency", k, 7);
    chk_dice("spin_entry", 1, 1, 2);
    cyc(7);
    chk("spin7_die1", die1, 2);
    chk("spin7_die2", die2, 2);
    roll = 1'b1;
    wait_valid(k);
    chk("release_latency", k, 7);
    chk_dice("present1", 2, 3, 5);
    cyc(5);
    chk("hold_valid", roll_valid, 1);
    chk("hold_sum", sum, 5);
    roll_ack = 1'b1; cyc(1); roll_ack = 1'b0;
    chk("ack1_valid", roll_valid, 0);

    // early release: minimum spin governs
    reset = 1'b1; cyc(2); reset = 1'b0;
    roll = 1'b0;
    wait_spinning(k);
    cyc(2);
    roll = 1'b1;
    wait_valid(k);
    chk("min_spin_latency", k, 7);
    chk_dice("present2", 3, 2, 5);

    // presses during PRESENT are ignored
    roll = 1'b0; cyc(8); roll = 1'b1; cyc(8);
    chk_dice("present_frozen", 3, 2, 5);
    chk("present_frozen_valid", roll_valid, 1);
    roll_ack = 1'b1; cyc(1); roll_ack = 1'b0;
    chk("ack2_valid", roll_valid, 0);
    chk("ack2_spinning", spinning, 0);
    chk("idle_hold_die1", die1, 3);
    cyc(3);
    chk("no_stale_press", spinning, 0);
    roll_ack = 1'b1; cyc(3); roll_ack = 1'b0;
    chk("ack_idle_ignored", roll_valid, 0);

    // reset on the 5th SPIN cycle, button held through reset
    roll = 1'b0;
    wait_spinning(k);
    cyc(4);
    reset = 1'b1; cyc(1);
    chk_dice("mid_spin_reset", 1, 1, 2);
    chk("mid_spin_reset_spinning", spinning, 0);
    chk("mid_spin_reset_valid", roll_valid, 0);
    cyc(1); reset = 1'b0;
    wait_spinning(k);
    chk("held_through_reset", k, 7);
    roll = 1'b1;
    wait_valid(k);
    roll_ack = 1'b1; cyc(1); roll_ack = 1'b0;
    cyc(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
